// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART byte receiver: header hunt, payload, XOR check, valid/ready hold.
// Optional inter-byte timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic [8*PAYLOAD_LEN-1:0] pkt_data_o,
  output logic                     pkt_valid_o,
  input  logic                     pkt_ready_i,
  output logic                     err_chk_o,
  output logic                     err_to_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int unsigned CntW = $clog2(PAYLOAD_LEN);

  typedef enum logic [1:0] {StHunt, StPayload, StCheck, StHold} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [7:0]               chk_q, chk_d;
  logic [8*PAYLOAD_LEN-1:0] data_q, data_d;
  logic                     pkt_valid_q, pkt_valid_d;
  logic                     err_chk_q, err_chk_d;
  logic                     overrun_q, overrun_d;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            err_to_q, err_to_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    err_chk_d   = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
    tmr_d    = tmr_q;
    err_to_d = 1'b0;
    // A byte on the expiry cycle wins, so the timer only advances on silent cycles.
    if ((state_q == StPayload || state_q == StCheck) && !rx_valid_i) begin
      if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
        err_to_d = 1'b1;
        state_d  = StHunt;
      end else begin
        tmr_d = tmr_q + TmrW'(1);
      end
    end
    if (rx_valid_i && (state_q == StPayload || state_q == StCheck)) begin
      tmr_d = '0;
    end
`endif
    unique case (state_q)
      StHunt: begin
        if (rx_valid_i && rx_data_i == HEADER) begin
          state_d = StPayload;
          cnt_d   = '0;
          chk_d   = 8'h00;
`ifdef UART_PKT_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
      end
      StPayload: begin
        if (rx_valid_i) begin
          data_d[8*int'(cnt_q) +: 8] = rx_data_i;
          chk_d = chk_q ^ rx_data_i;
          if (cnt_q == CntW'(PAYLOAD_LEN - 1)) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StCheck: begin
        if (rx_valid_i) begin
          if (rx_data_i == chk_q) begin
            state_d     = StHold;
            pkt_valid_d = 1'b1;
          end else begin
            state_d   = StHunt;
            err_chk_d = 1'b1;
          end
        end
      end
      StHold: begin
        // Bytes while holding are dropped, even on the acceptance cycle.
        overrun_d = rx_valid_i;
        if (pkt_ready_i) begin
          pkt_valid_d = 1'b0;
          state_d     = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      chk_q       <= 8'h00;
      data_q      <= '0;
      pkt_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
      tmr_q       <= '0;
      err_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      err_chk_q   <= err_chk_d;
      overrun_q   <= overrun_d;
`ifdef UART_PKT_TIMEOUT_EN
      tmr_q       <= tmr_d;
      err_to_q    <= err_to_d;
`endif
    end
  end

  assign pkt_data_o  = data_q;
  assign pkt_valid_o = pkt_valid_q;
  assign err_chk_o   = err_chk_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != StHunt);
`ifdef UART_PKT_TIMEOUT_EN
  assign err_to_o = err_to_q;
`else
  assign err_to_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: packet-level reference model pushes expected events,
// a negedge monitor pops them as the DUT reports packets, errors and overruns.
module tb_uart_rx_pkt_ctrl;

  localparam int unsigned Len   = 4;
  localparam int unsigned ToCyc = 20;
  localparam logic [7:0]  Hdr   = 8'hA5;
  localparam int EvPkt = 0, EvChk = 1, EvOvr = 2, EvTo = 3;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [7:0]      rx_data_i = 8'h00;
  logic            rx_valid_i = 1'b0;
  logic [8*Len-1:0] pkt_data_o;
  logic            pkt_valid_o;
  logic            pkt_ready_i = 1'b1;
  logic            err_chk_o, err_to_o, overrun_o, busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int          exp_kind_q[$];
  logic [31:0] exp_data_q[$];

  uart_rx_pkt_ctrl #(
    .PAYLOAD_LEN(Len),
    .HEADER     (Hdr),
    .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .pkt_data_o (pkt_data_o),
    .pkt_valid_o(pkt_valid_o),
    .pkt_ready_i(pkt_ready_i),
    .err_chk_o  (err_chk_o),
    .err_to_o   (err_to_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] data);
    exp_kind_q.push_back(kind);
    exp_data_q.push_back(data);
  endtask

  task automatic pop_check(input int kind, input logic [31:0] data);
    int          ek;
    logic [31:0] ed;
    n_checks++;
    if (exp_kind_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d data %h, expected none at %0t",
               kind, data, $time);
      return;
    end
    ek = exp_kind_q.pop_front();
    ed = exp_data_q.pop_front();
    if (ek != kind || (kind == EvPkt && ed !== data))
      $display("FAIL event: got kind %0d data %h, expected kind %0d data %h at %0t",
               kind, data, ek, ed, $time);
    else n_pass++;
  endtask

  // Monitor: one event per reported packet / pulse, plus hold-stability and exclusivity.
  initial begin
    logic        prev_valid;
    logic [31:0] held;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (pkt_valid_o && !prev_valid) begin
          pop_check(EvPkt, pkt_data_o);
          held = pkt_data_o;
        end else if (pkt_valid_o) begin
          check("hold_stable", pkt_data_o, held);
        end
        if (err_chk_o) pop_check(EvChk, 32'h0);
        if (err_to_o)  pop_check(EvTo, 32'h0);
        if (overrun_o) pop_check(EvOvr, 32'h0);
        if ((32'(err_chk_o) + 32'(err_to_o) + 32'(overrun_o)) > 1)
          check("pulse_exclusive", {29'h0, err_chk_o, err_to_o, overrun_o}, 32'h0);
        prev_valid = pkt_valid_o;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  function automatic logic [7:0] xor_sum(input logic [31:0] p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < Len; i++) s = s ^ p[8*i +: 8];
    return s;
  endfunction

  task automatic send_pkt(input logic [31:0] payload, input logic [7:0] chk_xor, input int gap);
    logic [7:0] chk;
    chk = xor_sum(payload) ^ chk_xor;
    send_byte(Hdr);
    for (int i = 0; i < Len; i++) begin
      idle(gap);
      send_byte(payload[8*i +: 8]);
    end
    idle(gap);
    if (chk_xor == 8'h00) expect_ev(EvPkt, payload);
    else expect_ev(EvChk, 32'h0);
    send_byte(chk);
    @(negedge clk_i);
    check("valid_latency", {31'h0, pkt_valid_o}, {31'h0, (chk_xor == 8'h00)});
    @(posedge clk_i);
    #1;
    if (chk_xor != 8'h00 || pkt_ready_i) begin
      check("valid_dropped", {31'h0, pkt_valid_o}, 32'h0);
      check("busy_idle", {31'h0, busy_o}, 32'h0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {pkt_data_o, pkt_valid_o, err_chk_o, err_to_o, overrun_o, busy_o}, '0);
  endtask

  logic [31:0] rp;
  logic [7:0]  rb;

  initial begin
    idle(3);
    check("reset_outputs", {pkt_valid_o, err_chk_o, err_to_o, overrun_o, busy_o}, '0);
    check("reset_data", pkt_data_o, 32'h0);
    rst_i = 1'b0;
    idle(2);

    // Good packet, immediate accept.
    send_pkt(32'h44332211, 8'h00, 0);
    // Bad checksum then a good one.
    send_pkt(32'h04030201, 8'h04, 0);
    send_pkt(32'hDEADBEEF, 8'h00, 1);

    // Hunt noise and header values inside the payload.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_pkt(32'hA5A5A5A5, 8'h00, 0);

    // Backpressure with overruns, including a header-valued byte.
    pkt_ready_i = 1'b0;
    send_pkt(32'hCAFEF00D, 8'h00, 0);
    idle(10);
    expect_ev(EvOvr, 32'h0);
    send_byte(8'h5A);
    idle(15);
    expect_ev(EvOvr, 32'h0);
    send_byte(Hdr);
    idle(22);
    check("hold_busy", {31'h0, busy_o}, 32'h1);
    pkt_ready_i = 1'b1;
    idle(1);
    check("accept_valid", {31'h0, pkt_valid_o}, 32'h0);
    send_pkt(32'h12345678, 8'h00, 0);

    // Inter-byte silence.
    send_byte(Hdr);
    send_byte(8'h11);
`ifdef UART_PKT_TIMEOUT_EN
    expect_ev(EvTo, 32'h0);
    repeat (ToCyc) @(posedge clk_i);
    @(negedge clk_i);
    check("timeout_timing", {31'h0, err_to_o}, 32'h1);
    @(posedge clk_i);
    #1;
    check("timeout_hunt", {31'h0, busy_o}, 32'h0);
    // Byte landing on the expiry cycle keeps the packet alive.
    rp = 32'h44332211;
    send_byte(Hdr);
    send_byte(rp[7:0]);
    idle(ToCyc - 1);
    send_byte(rp[15:8]);
    send_byte(rp[23:16]);
    send_byte(rp[31:24]);
    expect_ev(EvPkt, rp);
    send_byte(xor_sum(rp));
    idle(2);
`else
    idle(3 * ToCyc);
    check("no_timeout_busy", {31'h0, busy_o}, 32'h1);
    rp = 32'h44332211;
    send_byte(rp[15:8]);
    send_byte(rp[23:16]);
    send_byte(rp[31:24]);
    expect_ev(EvPkt, rp);
    send_byte(xor_sum(rp));
    idle(2);
`endif

    // Reset mid-packet discards everything.
    send_byte(Hdr);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check_idle_outputs("reset_midpkt");
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h44);
    idle(2);
    check("reset_ignored_busy", {31'h0, busy_o}, 32'h0);

    // Randomized packets, noise, corruption and backpressure.
    for (int i = 0; i < 150; i++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        rb = 8'($urandom);
        if (rb == Hdr) rb = 8'h00;
        send_byte(rb);
        idle($urandom_range(0, 2));
      end
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rb = 8'($urandom_range(1, 255));
        send_pkt(rp, rb, $urandom_range(0, 3));
      end else if ($urandom_range(0, 2) == 0) begin
        pkt_ready_i = 1'b0;
        send_pkt(rp, 8'h00, $urandom_range(0, 3));
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
          idle($urandom_range(0, 3));
          expect_ev(EvOvr, 32'h0);
          send_byte(8'($urandom));
        end
        idle($urandom_range(0, 4));
        pkt_ready_i = 1'b1;
        idle(1);
        check("rand_accept", {31'h0, pkt_valid_o}, 32'h0);
      end else begin
        send_pkt(rp, 8'h00, $urandom_range(0, 3));
      end
    end

    idle(5);
    check("scoreboard_empty", 32'(exp_kind_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
